// File: rtl/banked_word_memory.sv
// Banked word store: WORD_W-bit words packed four per 128-bit line across BANKS SRAM macros,
// valid/ready request/response handshake and a hardware clear sweep. Optional: BANKED_MEM_PARITY_EN.

// Behavioural model of the 64x128 single-port macro (active-low CEN/WEN/BWEN, registered Q).
module S011HD1P_X32Y2D128_BW (
    output logic [127:0] Q,
    input  logic         CLK,
    input  logic         CEN,
    input  logic         WEN,
    input  logic [127:0] BWEN,
    input  logic [5:0]   A,
    input  logic [127:0] D
);
    logic [127:0] mem [64];

    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (!WEN) mem[A] <= (mem[A] & BWEN) | (D & ~BWEN);
            else      Q      <= mem[A];
        end
    end
endmodule

module banked_word_memory #(
    parameter int WORD_W         = 31,
    parameter int BANKS          = 8,
    parameter int CLEAR_ON_RESET = 0,
    localparam int ADDR_W        = 8 + $clog2(BANKS)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_perr,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done
);
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
`ifdef BANKED_MEM_PARITY_EN
    localparam logic [31:0] LANE_MASK = ((32'h1 << WORD_W) - 32'h1) | 32'h8000_0000;
`else
    localparam logic [31:0] LANE_MASK = (32'h1 << WORD_W) - 32'h1;
`endif

    typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, RESP, CLEAR} state_t;

    state_t              state_q, state_d;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [WORD_W-1:0]   rdata_q;
    logic [5:0]          line_q;
    logic                done_q;
    logic                auto_clr_q;

    logic                accept;
    logic [BANK_W-1:0]   bank_sel;
    logic [1:0]          lane_sel;
    logic [BANKS-1:0]    cen_n;
    logic                wen_n;
    logic [127:0]        bwen_n;
    logic [127:0]        d_bus;
    logic [5:0]          a_bus;
    logic [127:0]        q_bus [BANKS];
    logic [127:0]        q_shift;
    logic [31:0]         wr_lane;
    logic [31:0]         rd_lane;

    assign req_ready  = resetn && (state_q == IDLE) && !clear_start && !auto_clr_q;
    assign accept     = req_valid && req_ready;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = rdata_q;
    assign clear_busy = (state_q == CLEAR);
    assign clear_done = done_q;

    assign bank_sel = BANK_W'(addr_q >> 8);
    assign lane_sel = addr_q[1:0];
    assign q_shift  = q_bus[bank_sel] >> {lane_sel, 5'd0};
    assign rd_lane  = q_shift[31:0];

    always_comb begin
        wr_lane             = '0;
        wr_lane[WORD_W-1:0] = wdata_q;
`ifdef BANKED_MEM_PARITY_EN
        wr_lane[31]         = ^wdata_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clear_start || auto_clr_q) state_d = CLEAR;
                else if (accept)               state_d = ACCESS;
            end
            ACCESS:  state_d = wr_q ? RESP : CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            CLEAR:   if (line_q == 6'd63) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Macro enables are gated by resetn so an in-flight sweep stops writing as soon as reset is seen.
    always_comb begin
        cen_n  = '1;
        wen_n  = 1'b1;
        bwen_n = '1;
        d_bus  = '0;
        a_bus  = addr_q[7:2];
        if (resetn && state_q == ACCESS) begin
            cen_n[bank_sel] = 1'b0;
            if (wr_q) begin
                wen_n  = 1'b0;
                bwen_n = ~({96'd0, LANE_MASK} << {lane_sel, 5'd0});
                d_bus  = {4{wr_lane}};
            end
        end else if (resetn && state_q == CLEAR) begin
            cen_n  = '0;
            wen_n  = 1'b0;
            bwen_n = '0;
            a_bus  = line_q;
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        S011HD1P_X32Y2D128_BW u_sram (
            .Q    (q_bus[b]),
            .CLK  (clk),
            .CEN  (cen_n[b]),
            .WEN  (wen_n),
            .BWEN (bwen_n),
            .A    (a_bus),
            .D    (d_bus)
        );
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            line_q     <= '0;
            done_q     <= 1'b0;
            auto_clr_q <= (CLEAR_ON_RESET != 0);
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == CLEAR) && (line_q == 6'd63);
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == CAPTURE) rdata_q <= rd_lane[WORD_W-1:0];
            if (state_q == CLEAR) begin
                line_q     <= line_q + 6'd1;
                auto_clr_q <= 1'b0;
            end
        end
    end

`ifdef BANKED_MEM_PARITY_EN
    logic perr_q;
    assign rsp_perr = perr_q;

    always_ff @(posedge clk) begin
        if (!resetn)                          perr_q <= 1'b0;
        else if (state_q == ACCESS && wr_q)   perr_q <= 1'b0;
        else if (state_q == CAPTURE)          perr_q <= ^{rd_lane[31], rd_lane[WORD_W-1:0]};
    end
`else
    assign rsp_perr = 1'b0;
`endif
endmodule

// File: tb/tb_banked_word_memory.sv
// Scoreboard bench for banked_word_memory: requests push expected responses, a negedge monitor pops them.
module tb_banked_word_memory;
    localparam int WORD_W = 31;
    localparam int BANKS  = 8;
    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_perr;
    logic              clear_start;
    logic              clear_busy;
    logic              clear_done;

    always #5 clk = ~clk;

    banked_word_memory #(.WORD_W(WORD_W), .BANKS(BANKS), .CLEAR_ON_RESET(0)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_perr    (rsp_perr),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done)
    );

    typedef struct packed {
        logic [WORD_W-1:0] d;
        logic              p;
    } rsp_t;

    rsp_t              sb[$];
    logic [WORD_W-1:0] exp_mem [2**ADDR_W];
    logic              perr_mem [2**ADDR_W];
    logic [WORD_W-1:0] prev_rdata;
    int                n_checks = 0;
    int                n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (resetn && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_rdata", 32'(rsp_rdata), 32'(e.d));
                check("rsp_perr", 32'(rsp_perr), 32'(e.p));
            end
        end
    end

    task automatic do_req(input logic w, input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d,
                          input bit chk_lat);
        int   t;
        int   cyc;
        rsp_t e;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready && t < 50);
        if (!req_ready) begin
            check("req_accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (w) begin
            exp_mem[a]  = d;
            perr_mem[a] = 1'b0;
            e.d = prev_rdata;
            e.p = 1'b0;
        end else begin
            e.d = exp_mem[a];
            e.p = perr_mem[a];
            prev_rdata = exp_mem[a];
        end
        sb.push_back(e);
        #1 req_valid = 1'b0;
        cyc = 1;
        do begin
            cyc++;
            @(negedge clk);
        end while (!rsp_valid && cyc < 30);
        if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
        else if (chk_lat && w) check("lat_wr", 32'(cyc), 32'd3);
        else if (chk_lat) check("lat_rd", 32'(cyc), 32'd4);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt, done_cnt, rdy_bad, t, n;
        logic prev_busy, done_ok;

        resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; clear_start = 1'b0; prev_rdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_perr", 32'(rsp_perr), 32'd0);
        check("rst_clear_busy", 32'(clear_busy), 32'd0);
        check("rst_clear_done", 32'(clear_done), 32'd0);
        @(posedge clk);
        #1;

        // basic write/read with latency
        do_req(1'b1, 11'h000, 31'h1234_5678, 1'b1);
        do_req(1'b0, 11'h000, '0, 1'b1);

        // lane isolation
        for (int i = 0; i < 4; i++) do_req(1'b1, 11'(32'h104 + i), 31'(i + 1), 1'b0);
        for (int i = 0; i < 4; i++) do_req(1'b0, 11'(32'h104 + i), '0, 1'b0);

        // bank isolation
        do_req(1'b1, 11'h0FF, 31'h0AAA_AAAA, 1'b0);
        do_req(1'b1, 11'h7FF, 31'h0555_5555, 1'b0);
        do_req(1'b0, 11'h0FF, '0, 1'b0);
        do_req(1'b0, 11'h7FF, '0, 1'b0);

        // backpressure
        rsp_ready = 1'b0;
        do_req(1'b0, 11'h105, '0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", 32'(rsp_rdata), 32'd2);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_idle_req_ready", 32'(req_ready), 32'd1);
        check("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // full clear sweep
        clear_start = 1'b1;
        @(negedge clk);
        check("clr_start_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 clear_start = 1'b0;
        busy_cnt = 0; done_cnt = 0; rdy_bad = 0; prev_busy = 1'b0; done_ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (clear_busy) busy_cnt++;
            if (req_ready && (clear_busy || i == 0)) rdy_bad++;
            if (clear_done) begin
                done_cnt++;
                done_ok = prev_busy && !clear_busy;
            end
            prev_busy = clear_busy;
        end
        check("clr_busy_cycles", 32'(busy_cnt), 32'd64);
        check("clr_done_pulses", 32'(done_cnt), 32'd1);
        check("clr_done_timing", 32'(done_ok), 32'd1);
        check("clr_req_ready_low", 32'(rdy_bad), 32'd0);
        @(posedge clk);
        #1;
        for (int a = 0; a < 2**ADDR_W; a++) begin
            exp_mem[a]  = '0;
            perr_mem[a] = 1'b0;
        end
        do_req(1'b0, 11'h000, '0, 1'b0);
        for (int i = 0; i < 4; i++) do_req(1'b0, 11'(32'h104 + i), '0, 1'b0);
        do_req(1'b0, 11'h0FF, '0, 1'b0);
        do_req(1'b0, 11'h7FF, '0, 1'b0);

        // reset in the middle of a second sweep; line 63 must survive untouched
        do_req(1'b1, 11'h0FF, 31'h0AAA_AAAA, 1'b0);
        do_req(1'b0, 11'h0FF, '0, 1'b0);
        clear_start = 1'b1;
        @(posedge clk);
        #1 clear_start = 1'b0;
        n = 0; t = 0;
        while (n < 20 && t < 100) begin
            @(negedge clk);
            t++;
            if (clear_busy) n++;
        end
        check("clr2_reached_20", 32'(n), 32'd20);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("clr2_rst_busy", 32'(clear_busy), 32'd0);
        check("clr2_rst_done", 32'(clear_done), 32'd0);
        check("clr2_rst_req_ready", 32'(req_ready), 32'd0);
        check("clr2_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("clr2_rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        prev_rdata = '0;
        @(negedge clk);
        check("clr2_after_busy", 32'(clear_busy), 32'd0);
        check("clr2_after_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        do_req(1'b0, 11'h0FF, '0, 1'b0);
        do_req(1'b1, 11'h3C1, 31'h7654_3210, 1'b0);
        do_req(1'b0, 11'h3C1, '0, 1'b1);

`ifdef BANKED_MEM_PARITY_EN
        do_req(1'b1, 11'h010, 31'h7, 1'b0);
        do_req(1'b0, 11'h010, '0, 1'b0);
        dut.g_bank[0].u_sram.mem[4][2] = ~dut.g_bank[0].u_sram.mem[4][2];
        exp_mem[11'h010]  = 31'h3;
        perr_mem[11'h010] = 1'b1;
        do_req(1'b0, 11'h010, '0, 1'b0);
`endif

        repeat (2) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
